// File: rtl/mem_requester_pkg.sv
// Shared types and constants for the data-memory requester.
// Imported by mem_requester and mem_lane_align.
package mem_requester_pkg;

    localparam int WORD_BYTES = 4;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_RSVD = 2'b11
    } size_e;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD   = 3'd1,
        ST_CAP  = 3'd2,
        ST_WR   = 3'd3,
        ST_RESP = 3'd4
    } state_e;

    // Halfwords need an even byte address, words a multiple of WORD_BYTES.
    function automatic logic is_misaligned(input size_e size, input logic [1:0] offset);
        logic bad;
        bad = 1'b0;
        case (size)
            SZ_HALF: bad = offset[0];
            SZ_WORD: bad = (offset != 2'b00);
            default: bad = 1'b0;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Little-endian lane handling: extracts and extends a load lane from a memory
// word, and merges a store lane into a memory word for read-modify-write.
module mem_lane_align
    import mem_requester_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  offset,
    input  size_e       size,
    input  logic        is_signed,
    input  logic [31:0] store_data,
    output logic [31:0] load_data,
    output logic [31:0] merged_word
);

    logic [7:0]  lane_byte;
    logic [15:0] lane_half;

    always_comb begin
        lane_byte   = word[offset*8 +: 8];
        lane_half   = word[{offset[1], 4'b0000} +: 16];
        load_data   = word;
        merged_word = store_data;
        case (size)
            SZ_BYTE: begin
                load_data   = {{24{is_signed & lane_byte[7]}}, lane_byte};
                merged_word = word;
                merged_word[offset*8 +: 8] = store_data[7:0];
            end
            SZ_HALF: begin
                load_data   = {{16{is_signed & lane_half[15]}}, lane_half};
                merged_word = word;
                merged_word[{offset[1], 4'b0000} +: 16] = store_data[15:0];
            end
            default: begin
                load_data   = word;
                merged_word = store_data;
            end
        endcase
    end

endmodule

// File: rtl/mem_requester.sv
// Load/store initiator for a word-addressed data memory; sub-word stores use
// read-modify-write. Optional macro MEM_REQUESTER_BOUNDS_CHECK_EN rejects out-of-range addresses.
module mem_requester
    import mem_requester_pkg::*;
#(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [31:0]       req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic              mem_we,
    output logic              mem_re,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    state_e            state;
    size_e             req_size_e;
    logic              req_bad;

    logic              cap_we;
    logic              cap_signed;
    size_e             cap_size;
    logic [1:0]        cap_offset;
    logic [DATA_W-1:0] cap_wdata;

    logic [DATA_W-1:0] lane_load;
    logic [DATA_W-1:0] lane_merged;

    assign req_ready  = (state == ST_IDLE);
    assign req_size_e = size_e'(req_size);

`ifdef MEM_REQUESTER_BOUNDS_CHECK_EN
    always_comb begin
        req_bad = (req_size_e == SZ_RSVD)
                | is_misaligned(req_size_e, req_addr[1:0])
                | (req_addr[31:ADDR_W+2] != '0);
    end
`else
    // Upper address bits are dropped so accesses wrap into the memory.
    logic unused_upper_addr;
    assign unused_upper_addr = ^req_addr[31:ADDR_W+2];

    always_comb begin
        req_bad = (req_size_e == SZ_RSVD) | is_misaligned(req_size_e, req_addr[1:0]);
    end
`endif

    mem_lane_align u_lane_align (
        .word        (mem_rdata),
        .offset      (cap_offset),
        .size        (cap_size),
        .is_signed   (cap_signed),
        .store_data  (cap_wdata),
        .load_data   (lane_load),
        .merged_word (lane_merged)
    );

    // Request sequencer: all memory and response outputs are registered here.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            cap_we     <= 1'b0;
            cap_signed <= 1'b0;
            cap_size   <= SZ_BYTE;
            cap_offset <= 2'b00;
            cap_wdata  <= '0;
            mem_we     <= 1'b0;
            mem_re     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        cap_we     <= req_we;
                        cap_signed <= req_signed;
                        cap_size   <= req_size_e;
                        cap_offset <= req_addr[1:0];
                        cap_wdata  <= req_wdata;
                        resp_rdata <= '0;
                        if (req_bad) begin
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            state      <= ST_RESP;
                        end else if (req_we && (req_size_e == SZ_WORD)) begin
                            mem_addr  <= req_addr[ADDR_W+1:2];
                            mem_wdata <= req_wdata;
                            mem_we    <= 1'b1;
                            state     <= ST_WR;
                        end else begin
                            mem_addr <= req_addr[ADDR_W+1:2];
                            mem_re   <= 1'b1;
                            state    <= ST_RD;
                        end
                    end
                end
                ST_RD: begin
                    mem_re <= 1'b0;
                    state  <= ST_CAP;
                end
                ST_CAP: begin
                    if (cap_we) begin
                        mem_wdata <= lane_merged;
                        mem_we    <= 1'b1;
                        state     <= ST_WR;
                    end else begin
                        resp_rdata <= lane_load;
                        resp_valid <= 1'b1;
                        state      <= ST_RESP;
                    end
                end
                ST_WR: begin
                    mem_we     <= 1'b0;
                    resp_valid <= 1'b1;
                    state      <= ST_RESP;
                end
                ST_RESP: begin
                    resp_valid <= 1'b0;
                    resp_err   <= 1'b0;
                    state      <= ST_IDLE;
                end
                default: begin
                    mem_we     <= 1'b0;
                    mem_re     <= 1'b0;
                    resp_valid <= 1'b0;
                    resp_err   <= 1'b0;
                    state      <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_requester.sv
// Directed bench for mem_requester against a 128x32 synchronous RAM model.
// Cycle N of a transaction is sampled on the falling edge before rising edge N.
module tb_mem_requester;

    localparam int ADDR_W = 7;

    logic              clk = 1'b0;
    logic              reset;
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [1:0]        req_size;
    logic              req_signed;
    logic [31:0]       req_addr;
    logic [31:0]       req_wdata;
    logic              resp_valid;
    logic [31:0]       resp_rdata;
    logic              resp_err;
    logic              mem_we;
    logic              mem_re;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;

    logic [31:0]       mem [0:127];
    logic              bd_we;
    logic [ADDR_W-1:0] bd_addr;
    logic [31:0]       bd_data;

    int                assertions;
    int                failures;
    logic [31:0]       got_rdata;
    logic              got_err;
    int                got_lat;
    int                we_cnt;
    int                re_cnt;
    int                resp_cnt;
    logic [ADDR_W-1:0] we_addr;

    mem_requester #(.ADDR_W(ADDR_W), .DATA_W(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_size   (req_size),
        .req_signed (req_signed),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_we     (mem_we),
        .mem_re     (mem_re),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    // RAM model: read data appears the cycle after mem_re; bd_* is a backdoor preload port.
    always @(posedge clk) begin
        if (mem_re) mem_rdata <= mem[mem_addr];
        if (mem_we) mem[mem_addr] <= mem_wdata;
        if (bd_we) mem[bd_addr] <= bd_data;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assertions++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic preload(input logic [ADDR_W-1:0] addr, input logic [31:0] data);
        @(negedge clk);
        bd_we   = 1'b1;
        bd_addr = addr;
        bd_data = data;
        @(negedge clk);
        bd_we = 1'b0;
    endtask

    // Issues one request and records latency, response and memory strobe activity.
    task automatic applyStimulus(input logic we, input logic [1:0] size, input logic sgn,
                                 input logic [31:0] addr, input logic [31:0] wdata);
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = we;
        req_size   = size;
        req_signed = sgn;
        req_addr   = addr;
        req_wdata  = wdata;
        @(posedge clk);
        #1 req_valid = 1'b0;
        got_lat   = 0;
        we_cnt    = 0;
        re_cnt    = 0;
        got_err   = 1'bx;
        got_rdata = 32'hxxxxxxxx;
        we_addr   = '0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (mem_we) begin
                we_cnt++;
                we_addr = mem_addr;
            end
            if (mem_re) re_cnt++;
            if (resp_valid) begin
                got_lat   = c;
                got_rdata = resp_rdata;
                got_err   = resp_err;
                break;
            end
        end
    endtask

    initial begin
        assertions = 0;
        failures   = 0;
        reset      = 1'b1;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_size   = 2'b00;
        req_signed = 1'b0;
        req_addr   = '0;
        req_wdata  = '0;
        bd_we      = 1'b0;
        bd_addr    = '0;
        bd_data    = '0;
        mem_rdata  = '0;
        for (int i = 0; i < 128; i++) mem[i] = 32'h0;

        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        $display("[TB] reset state");
        checkOutput("rst_req_ready", {31'b0, req_ready}, 32'd1);
        checkOutput("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
        checkOutput("rst_mem_we", {31'b0, mem_we}, 32'd0);
        checkOutput("rst_mem_re", {31'b0, mem_re}, 32'd0);
        checkOutput("rst_mem_addr", {25'b0, mem_addr}, 32'd0);
        checkOutput("rst_resp_rdata", resp_rdata, 32'd0);

        $display("[TB] word store then word load");
        applyStimulus(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF);
        checkOutput("sw_latency", got_lat, 32'd2);
        checkOutput("sw_we_count", we_cnt, 32'd1);
        checkOutput("sw_re_count", re_cnt, 32'd0);
        checkOutput("sw_we_addr", {25'b0, we_addr}, 32'd4);
        checkOutput("sw_rdata", got_rdata, 32'd0);
        checkOutput("sw_mem4", mem[4], 32'hDEADBEEF);
        applyStimulus(1'b0, 2'b10, 1'b1, 32'h10, 32'h0);
        checkOutput("lw_latency", got_lat, 32'd3);
        checkOutput("lw_rdata", got_rdata, 32'hDEADBEEF);
        checkOutput("lw_err", {31'b0, got_err}, 32'd0);

        $display("[TB] byte and half loads");
        preload(7'd4, 32'h80FF7F01);
        applyStimulus(1'b0, 2'b00, 1'b1, 32'h13, 32'h0);
        checkOutput("lb_0x13", got_rdata, 32'hFFFFFF80);
        applyStimulus(1'b0, 2'b00, 1'b0, 32'h13, 32'h0);
        checkOutput("lbu_0x13", got_rdata, 32'h00000080);
        applyStimulus(1'b0, 2'b00, 1'b1, 32'h11, 32'h0);
        checkOutput("lb_0x11", got_rdata, 32'h0000007F);
        checkOutput("lb_latency", got_lat, 32'd3);
        applyStimulus(1'b0, 2'b01, 1'b1, 32'h12, 32'h0);
        checkOutput("lh_0x12", got_rdata, 32'hFFFF80FF);
        applyStimulus(1'b0, 2'b01, 1'b0, 32'h10, 32'h0);
        checkOutput("lhu_0x10", got_rdata, 32'h00007F01);

        $display("[TB] sub-word store merge");
        preload(7'd4, 32'h11223344);
        applyStimulus(1'b1, 2'b01, 1'b0, 32'h12, 32'h0000ABCD);
        checkOutput("sh_latency", got_lat, 32'd4);
        checkOutput("sh_we_count", we_cnt, 32'd1);
        checkOutput("sh_re_count", re_cnt, 32'd1);
        checkOutput("sh_mem4", mem[4], 32'hABCD3344);
        applyStimulus(1'b1, 2'b00, 1'b0, 32'h10, 32'h123456EE);
        checkOutput("sb_mem4", mem[4], 32'hABCD33EE);
        checkOutput("sb_err", {31'b0, got_err}, 32'd0);

        $display("[TB] error paths");
        applyStimulus(1'b0, 2'b10, 1'b0, 32'h11, 32'h0);
        checkOutput("lw_mis_err", {31'b0, got_err}, 32'd1);
        checkOutput("lw_mis_latency", got_lat, 32'd1);
        checkOutput("lw_mis_mem", we_cnt + re_cnt, 32'd0);
        applyStimulus(1'b1, 2'b01, 1'b0, 32'h13, 32'hFFFF);
        checkOutput("sh_mis_err", {31'b0, got_err}, 32'd1);
        checkOutput("sh_mis_latency", got_lat, 32'd1);
        checkOutput("sh_mis_mem", we_cnt + re_cnt, 32'd0);
        applyStimulus(1'b0, 2'b11, 1'b0, 32'h10, 32'h0);
        checkOutput("rsvd_err", {31'b0, got_err}, 32'd1);
        checkOutput("rsvd_latency", got_lat, 32'd1);
        checkOutput("rsvd_mem", we_cnt + re_cnt, 32'd0);
        checkOutput("err_mem4_intact", mem[4], 32'hABCD33EE);

        $display("[TB] upper address bits");
        preload(7'd0, 32'hCAFEF00D);
        applyStimulus(1'b0, 2'b10, 1'b0, 32'h00000200, 32'h0);
`ifdef MEM_REQUESTER_BOUNDS_CHECK_EN
        checkOutput("oob_err", {31'b0, got_err}, 32'd1);
        checkOutput("oob_latency", got_lat, 32'd1);
`else
        checkOutput("wrap_err", {31'b0, got_err}, 32'd0);
        checkOutput("wrap_rdata", got_rdata, 32'hCAFEF00D);
`endif

        $display("[TB] reset during read-modify-write");
        preload(7'd5, 32'h55667788);
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_size   = 2'b00;
        req_signed = 1'b0;
        req_addr   = 32'h15;
        req_wdata  = 32'h99;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        checkOutput("midrst_mem_we", {31'b0, mem_we}, 32'd0);
        checkOutput("midrst_ready_async", {31'b0, req_ready}, 32'd1);
        @(negedge clk);
        reset = 1'b0;
        we_cnt   = 0;
        resp_cnt = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (mem_we) we_cnt++;
            if (resp_valid) resp_cnt++;
        end
        checkOutput("midrst_we_count", we_cnt, 32'd0);
        checkOutput("midrst_resp_count", resp_cnt, 32'd0);
        checkOutput("midrst_req_ready", {31'b0, req_ready}, 32'd1);
        checkOutput("midrst_mem5", mem[5], 32'h55667788);

        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
